// File: rtl/img_mem_port_arbiter.sv
// rtl/img_mem_port_arbiter.sv - burst-locked arbiter sharing the image BRAM port among host, loader and write-back
// Optional per-requester beat/wait counters are built when ARB_PERF_CNT_EN is defined.
module img_mem_port_arbiter #(
    parameter int ADDR_BITS    = 11,
    parameter int N            = 4,
    parameter int MAX_BURST    = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 h_req,
    input  logic [ADDR_BITS-1:0] h_addr,
    input  logic [7:0]           h_data,
    output logic                 h_gnt,
    input  logic                 ld_req,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic                 ld_last,
    output logic                 ld_gnt,
    output logic                 ld_rvalid,
    output logic [N*8-1:0]       ld_rdata,
    input  logic                 wb_req,
    input  logic [ADDR_BITS-1:0] wb_addr,
    input  logic [N-1:0]         wb_be,
    input  logic [N*8-1:0]       wb_wdata,
    input  logic                 wb_last,
    output logic                 wb_gnt,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [N-1:0]         mem_be,
    output logic [N*8-1:0]       mem_wdata,
    input  logic [N*8-1:0]       mem_rdata,
    output logic [1:0]           owner,
    output logic                 burst_viol
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [2:0][15:0]     perf_beats,
    output logic [2:0][15:0]     perf_wait
`endif
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] OWN_H    = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_WB   = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    typedef enum logic {S_ARB, S_GRANT} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_owner;
    logic [1:0]        w_next_owner;
    logic              r_rr_wb;
    logic              w_next_rr_wb;
    logic [BC_W-1:0]   r_beat_cnt;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_burst_viol;
    logic              r_rvalid;

    logic              w_lane_pend;
    logic              w_host_win;
    logic              w_beat;
    logic              w_last;
    logic              w_force;
    logic              w_lane_win;

    assign w_lane_pend = ld_req | wb_req;
    assign w_host_win  = h_req && !((r_starve_cnt == SC_W'(STARVE_LIMIT)) && w_lane_pend);

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_rr_wb = r_rr_wb;
        w_lane_win   = 1'b0;
        w_beat       = 1'b0;
        w_last       = 1'b0;
        w_force      = 1'b0;
        h_gnt        = 1'b0;
        ld_gnt       = 1'b0;
        wb_gnt       = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_be       = '0;
        mem_wdata    = '0;
        case (r_state)
            S_ARB: begin
                if (w_host_win) begin
                    w_next_owner = OWN_H;
                    w_next_state = S_GRANT;
                end else if (w_lane_pend) begin
                    w_lane_win   = 1'b1;
                    w_next_state = S_GRANT;
                    // Pointer marks the preferred lane; it moves past whichever lane wins.
                    if ((r_rr_wb && wb_req) || !ld_req) begin
                        w_next_owner = OWN_WB;
                        w_next_rr_wb = 1'b0;
                    end else begin
                        w_next_owner = OWN_LD;
                        w_next_rr_wb = 1'b1;
                    end
                end else begin
                    w_next_owner = OWN_NONE;
                end
            end
            S_GRANT: begin
                case (r_owner)
                    OWN_H: begin
                        h_gnt     = h_req;
                        w_beat    = h_req;
                        w_last    = 1'b1;
                        mem_we    = h_req;
                        mem_addr  = h_req ? h_addr : '0;
                        mem_be    = h_req ? N'(1) : '0;
                        mem_wdata = h_req ? (N*8)'(h_data) : '0;
                    end
                    OWN_LD: begin
                        ld_gnt    = ld_req;
                        w_beat    = ld_req;
                        w_last    = ld_last;
                        mem_addr  = ld_req ? ld_addr : '0;
                    end
                    OWN_WB: begin
                        wb_gnt    = wb_req;
                        w_beat    = wb_req;
                        w_last    = wb_last;
                        mem_we    = wb_req;
                        mem_addr  = wb_req ? wb_addr : '0;
                        mem_be    = wb_req ? wb_be : '0;
                        mem_wdata = wb_req ? wb_wdata : '0;
                    end
                    default: ;
                endcase
                mem_en  = w_beat;
                w_force = w_beat && !w_last && (r_beat_cnt == BC_W'(MAX_BURST - 1));
                if (w_beat && (w_last || w_force)) begin
                    w_next_state = S_ARB;
                    w_next_owner = OWN_NONE;
                end
            end
            default: begin
                w_next_state = S_ARB;
                w_next_owner = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_ARB;
            r_owner      <= OWN_NONE;
            r_rr_wb      <= 1'b0;
            r_beat_cnt   <= '0;
            r_starve_cnt <= '0;
            r_burst_viol <= 1'b0;
            r_rvalid     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_next_owner;
            r_rr_wb      <= w_next_rr_wb;
            r_burst_viol <= r_burst_viol | w_force;
            r_rvalid     <= ld_gnt;
            if (r_state == S_ARB)
                r_beat_cnt <= '0;
            else if (w_beat)
                r_beat_cnt <= r_beat_cnt + BC_W'(1);
            if (w_lane_win)
                r_starve_cnt <= '0;
            else if (h_gnt && w_lane_pend && (r_starve_cnt != SC_W'(STARVE_LIMIT)))
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end
    end

    assign owner      = r_owner;
    assign burst_viol = r_burst_viol;
    assign ld_rvalid  = r_rvalid;
    assign ld_rdata   = r_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [2:0][15:0] r_perf_beats;
    logic [2:0][15:0] r_perf_wait;
    logic [2:0]       w_req_vec;
    logic [2:0]       w_gnt_vec;

    assign w_req_vec = {wb_req, ld_req, h_req};
    assign w_gnt_vec = {wb_gnt, ld_gnt, h_gnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_beats <= '0;
            r_perf_wait  <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_gnt_vec[k] && (r_perf_beats[k] != 16'hFFFF))
                    r_perf_beats[k] <= r_perf_beats[k] + 16'd1;
                if (w_req_vec[k] && !w_gnt_vec[k] && (r_perf_wait[k] != 16'hFFFF))
                    r_perf_wait[k] <= r_perf_wait[k] + 16'd1;
            end
        end
    end

    assign perf_beats = r_perf_beats;
    assign perf_wait  = r_perf_wait;
`endif

endmodule

// File: tb/tb_img_mem_port_arbiter.sv
// tb/tb_img_mem_port_arbiter.sv - directed vector bench for img_mem_port_arbiter
module tb_img_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_req = 1'b0;
    logic [10:0] h_addr = '0;
    logic [7:0]  h_data = '0;
    logic        h_gnt;
    logic        ld_req = 1'b0;
    logic [10:0] ld_addr = '0;
    logic        ld_last = 1'b0;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        wb_req = 1'b0;
    logic [10:0] wb_addr = '0;
    logic [3:0]  wb_be = '0;
    logic [31:0] wb_wdata = '0;
    logic        wb_last = 1'b0;
    logic        wb_gnt;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  owner;
    logic        burst_viol;

    int n_tests = 0;
    int n_fail  = 0;

    img_mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_addr(h_addr), .h_data(h_data), .h_gnt(h_gnt),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_last(ld_last), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_be(wb_be), .wb_wdata(wb_wdata),
        .wb_last(wb_last), .wb_gnt(wb_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .burst_viol(burst_viol)
    );

    always #5 clk = ~clk;

    // Memory model: byte k of a read at address a holds (a+k) mod 256.
    always @(posedge clk) begin
        if (mem_en && !mem_we)
            mem_rdata <= {mem_addr[7:0] + 8'd3, mem_addr[7:0] + 8'd2,
                          mem_addr[7:0] + 8'd1, mem_addr[7:0]};
    end

    typedef struct {
        logic        hq;
        logic [10:0] ha;
        logic [7:0]  hd;
        logic        lq;
        logic [10:0] la;
        logic        ll;
        logic        wq;
        logic [10:0] wa;
        logic [3:0]  wbe;
        logic [31:0] wd;
        logic        wl;
        logic [2:0]  e_gnt;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_en;
        logic        e_we;
        logic [10:0] e_ad;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [1:0]  e_own;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        h_req = 0; ld_req = 0; wb_req = 0; ld_last = 0; wb_last = 0;
        h_addr = '0; h_data = '0; ld_addr = '0; wb_addr = '0; wb_be = '0; wb_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [127:0] outs();
        return {41'd0, wb_gnt, ld_gnt, h_gnt, ld_rvalid, ld_rdata, mem_en, mem_we,
                mem_addr, mem_be, mem_wdata, owner};
    endfunction

    task automatic lane_pick(input string name, input logic [1:0] exp_own);
        logic got;
        logic [1:0] who;
        got = 0;
        who = 2'd3;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            ld_req = 1; wb_req = 1; ld_last = 1; wb_last = 1;
            #1;
            if (ld_gnt || wb_gnt) begin
                got = 1;
                who = ld_gnt ? 2'd1 : 2'd2;
            end
        end
        check(name, {126'd0, who}, {126'd0, exp_own});
    endtask

    int cnt;
    logic seen;
    logic ok;

    initial begin
        //            hq ha     hd     lq la     ll wq wa      wbe    wd            wl gnt     rv rd             en we ad      be     wd            own
        vecs[0]  = '{0, 'h000, 'h00, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[1]  = '{1, 'h010, 'hA5, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[2]  = '{1, 'h010, 'hA5, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b001, 0, 'h00000000, 1, 1, 'h010, 'h1, 'h000000A5, 0};
        vecs[3]  = '{0, 'h000, 'h00, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[4]  = '{0, 'h000, 'h00, 1, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[5]  = '{0, 'h000, 'h00, 1, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b010, 0, 'h00000000, 1, 0, 'h000, 'h0, 'h00000000, 1};
        vecs[6]  = '{0, 'h000, 'h00, 1, 'h004, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b010, 1, 'h03020100, 1, 0, 'h004, 'h0, 'h00000000, 1};
        vecs[7]  = '{0, 'h000, 'h00, 1, 'h008, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b010, 1, 'h07060504, 1, 0, 'h008, 'h0, 'h00000000, 1};
        vecs[8]  = '{0, 'h000, 'h00, 1, 'h00C, 1, 0, 'h000, 'h0, 'h00000000, 0, 3'b010, 1, 'h0B0A0908, 1, 0, 'h00C, 'h0, 'h00000000, 1};
        vecs[9]  = '{0, 'h000, 'h00, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 1, 'h0F0E0D0C, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[10] = '{0, 'h000, 'h00, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[11] = '{0, 'h000, 'h00, 0, 'h000, 0, 1, 'h400, 'hA, 'hDEADBEEF, 1, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[12] = '{0, 'h000, 'h00, 0, 'h000, 0, 1, 'h400, 'hA, 'hDEADBEEF, 1, 3'b100, 0, 'h00000000, 1, 1, 'h400, 'hA, 'hDEADBEEF, 2};
        vecs[13] = '{0, 'h000, 'h00, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[14] = '{0, 'h000, 'h00, 1, 'h014, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[15] = '{0, 'h000, 'h00, 1, 'h014, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b010, 0, 'h00000000, 1, 0, 'h014, 'h0, 'h00000000, 1};
        vecs[16] = '{1, 'h011, 'h3C, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 1, 'h17161514, 0, 0, 'h000, 'h0, 'h00000000, 1};
        vecs[17] = '{1, 'h011, 'h3C, 1, 'h018, 1, 0, 'h000, 'h0, 'h00000000, 0, 3'b010, 0, 'h00000000, 1, 0, 'h018, 'h0, 'h00000000, 1};
        vecs[18] = '{1, 'h011, 'h3C, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 1, 'h1B1A1918, 0, 0, 'h000, 'h0, 'h00000000, 3};
        vecs[19] = '{1, 'h011, 'h3C, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b001, 0, 'h00000000, 1, 1, 'h011, 'h1, 'h0000003C, 0};
        vecs[20] = '{0, 'h000, 'h00, 0, 'h000, 0, 0, 'h000, 'h0, 'h00000000, 0, 3'b000, 0, 'h00000000, 0, 0, 'h000, 'h0, 'h00000000, 3};

        // Reset state
        idle_inputs();
        @(negedge clk);
        #1;
        check("reset_outputs", outs(), {41'd0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0, 2'd3});
        check("reset_burst_viol", {127'd0, burst_viol}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven cycle vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            h_req = vecs[i].hq; h_addr = vecs[i].ha; h_data = vecs[i].hd;
            ld_req = vecs[i].lq; ld_addr = vecs[i].la; ld_last = vecs[i].ll;
            wb_req = vecs[i].wq; wb_addr = vecs[i].wa; wb_be = vecs[i].wbe;
            wb_wdata = vecs[i].wd; wb_last = vecs[i].wl;
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {41'd0, vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_rd, vecs[i].e_en, vecs[i].e_we,
                   vecs[i].e_ad, vecs[i].e_be, vecs[i].e_wd, vecs[i].e_own});
        end

        // Round-robin between loader and write-back
        do_reset();
        lane_pick("rr_first_after_reset", 2'd1);
        @(negedge clk); idle_inputs();
        @(negedge clk);
        lane_pick("rr_second_contention", 2'd2);
        lane_pick("rr_third_contention", 2'd1);
        @(negedge clk); idle_inputs();

        // Starvation guard
        do_reset();
        cnt = 0; seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            h_req = 1; ld_req = 1; ld_last = 1;
            #1;
            if (h_gnt) cnt++;
            if (ld_gnt) seen = 1;
        end
        check("starve_loader_granted", {127'd0, seen}, 128'd1);
        check("starve_host_grants", 128'(cnt), 128'd8);
        @(negedge clk); idle_inputs();

        // Runaway write-back burst
        do_reset();
        @(negedge clk);
        wb_req = 1; wb_last = 0; wb_addr = 'h200; wb_be = 'hF; wb_wdata = 'h11223344;
        #1;
        check("runaway_viol_before", {127'd0, burst_viol}, 128'd0);
        cnt = 0; seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            ld_req = 1; ld_last = 1;
            #1;
            if (wb_gnt) cnt++;
            if (ld_gnt) seen = 1;
        end
        check("runaway_wb_beats", 128'(cnt), 128'd16);
        check("runaway_owner_ld", {126'd0, owner}, 128'd1);
        check("runaway_burst_viol", {127'd0, burst_viol}, 128'd1);
        @(negedge clk); idle_inputs();

        // Reset during a loader burst with a read in flight
        do_reset();
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            ld_req = 1; ld_last = 0; ld_addr = 'h020;
            #1;
            if (ld_gnt) seen = 1;
        end
        check("midrst_loader_granted", {127'd0, seen}, 128'd1);
        @(posedge clk);
        #1;
        check("midrst_rvalid_before", {127'd0, ld_rvalid}, 128'd1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {123'd0, ld_gnt, mem_en, ld_rvalid, owner},
              {123'd0, 1'b0, 1'b0, 1'b0, 2'd3});
        ld_req = 0;
        @(negedge clk);
        rst = 1'b0;
        ok = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (ld_rvalid) ok = 0;
        end
        check("midrst_no_rvalid_after", {127'd0, ok}, 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
